// File: rtl/arb_pkg.sv
// Shared types, constants and the id-width helper for the parameterised priority arbiter.
package arb_pkg;

   localparam logic ARB_MODE_FIXED = 1'b0;
   localparam logic ARB_MODE_RR    = 1'b1;
   localparam int   ARB_MAX_N      = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   // A two-requester arbiter still needs one id bit, so the width never drops to zero
   function automatic int arb_id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/param_priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface param_priority_arbiter_if
   import arb_pkg::*;
#(
   parameter int N = 4
) ();

   localparam int IDW = arb_id_width(N);

   logic [N-1:0]   req;
   logic           rr_mode;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [IDW-1:0] gnt_id;
   logic           hold_expired;

   modport master (
      output req,
      output rr_mode,
      input  gnt,
      input  gnt_valid,
      input  gnt_id,
      input  hold_expired
   );

   modport slave (
      input  req,
      input  rr_mode,
      output gnt,
      output gnt_valid,
      output gnt_id,
      output hold_expired
   );

endinterface

// File: rtl/arb_pick.sv
// Combinational masked picker: highest index in fixed mode, first set bit from start (with wrap) in RR mode.
module arb_pick
   import arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = arb_id_width(N)
) (
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   mask,
   input  logic [IDW-1:0] start,
   input  logic           mode,
   output logic [N-1:0]   win,
   output logic           any_valid
);

   logic [N-1:0]   masked;
   logic [IDW-1:0] fix_idx;
   logic [IDW-1:0] rr_idx;
   logic [IDW-1:0] sel;
   logic           found;
   int             j;

   always_comb begin
      masked    = req & mask;
      any_valid = |masked;

      fix_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (masked[i]) fix_idx = IDW'(i);
      end

      // Walk N positions starting at the pointer; the first hit is the RR winner
      rr_idx = '0;
      found  = 1'b0;
      j      = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(start) + k;
         if (j >= N) j = j - N;
         if (!found && masked[j]) begin
            rr_idx = IDW'(j);
            found  = 1'b1;
         end
      end

      sel = (mode == ARB_MODE_RR) ? rr_idx : fix_idx;
      win = '0;
      if (any_valid) win[sel] = 1'b1;
   end

endmodule

// File: rtl/param_priority_arbiter.sv
// N-requester locking arbiter with registered one-hot grant and fixed/RR mode.
// Optional hold limit with forced revocation is enabled by defining ARB_HOLD_LIMIT_EN.
module param_priority_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   param_priority_arbiter_if.slave bus
);

   localparam int IDW = arb_id_width(N);

   if (N < 2 || N > ARB_MAX_N || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
      $error("param_priority_arbiter: N or MAX_HOLD out of legal range");
   end

   arb_state_t     state;
   arb_state_t     state_nxt;
   logic [N-1:0]   gnt_q;
   logic [N-1:0]   gnt_nxt;
   logic [IDW-1:0] gnt_id_q;
   logic [IDW-1:0] gnt_id_nxt;
   logic           gnt_valid_q;
   logic           gnt_valid_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_nxt;

   logic [N-1:0]   win;
   logic [IDW-1:0] win_id;
   logic           any_valid;
   logic [N-1:0]   mask;
   logic           owner_req;
   logic           hold_hit;
   logic           arb_edge;

   assign owner_req = bus.req[gnt_id_q];

`ifdef ARB_HOLD_LIMIT_EN
   logic [7:0] hold_cnt;
   logic [7:0] hold_cnt_nxt;
   logic       hold_expired_q;
   logic       hold_expired_nxt;

   assign hold_hit         = (state == ST_BUSY) && owner_req && (hold_cnt == 8'(MAX_HOLD));
   assign bus.hold_expired = hold_expired_q;
`else
   assign hold_hit         = 1'b0;
   assign bus.hold_expired = 1'b0;
`endif

   // A hold-limit edge re-arbitrates with the current owner excluded
   assign arb_edge = (state == ST_IDLE) || !owner_req || hold_hit;
   assign mask     = hold_hit ? ~gnt_q : '1;

   arb_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req       (bus.req),
      .mask      (mask),
      .start     (ptr),
      .mode      (bus.rr_mode),
      .win       (win),
      .any_valid (any_valid)
   );

   always_comb begin
      win_id = '0;
      for (int i = 0; i < N; i++) begin
         if (win[i]) win_id = IDW'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         ptr         <= '0;
      end else begin
         state       <= state_nxt;
         gnt_q       <= gnt_nxt;
         gnt_id_q    <= gnt_id_nxt;
         gnt_valid_q <= gnt_valid_nxt;
         ptr         <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (arb_edge) state_nxt = (any_valid || hold_hit) ? ST_BUSY : ST_IDLE;
   end

   // A hold-limit edge with no competitor keeps the owner as-is
   always_comb begin
      gnt_nxt       = gnt_q;
      gnt_id_nxt    = gnt_id_q;
      gnt_valid_nxt = gnt_valid_q;
      ptr_nxt       = ptr;
      if (arb_edge && any_valid) begin
         gnt_nxt       = win;
         gnt_id_nxt    = win_id;
         gnt_valid_nxt = 1'b1;
         ptr_nxt       = (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
      end else if (arb_edge && !hold_hit) begin
         gnt_nxt       = '0;
         gnt_valid_nxt = 1'b0;
      end
   end

`ifdef ARB_HOLD_LIMIT_EN
   always_comb begin
      hold_cnt_nxt     = hold_cnt;
      hold_expired_nxt = 1'b0;
      if (arb_edge && (any_valid || hold_hit)) begin
         hold_cnt_nxt     = 8'd1;
         hold_expired_nxt = hold_hit && any_valid;
      end else if (state == ST_BUSY) begin
         hold_cnt_nxt = hold_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt       <= '0;
         hold_expired_q <= 1'b0;
      end else begin
         hold_cnt       <= hold_cnt_nxt;
         hold_expired_q <= hold_expired_nxt;
      end
   end
`endif

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_param_priority_arbiter.sv
// Directed self-checking bench for param_priority_arbiter (N=4, MAX_HOLD=4), with or without ARB_HOLD_LIMIT_EN.
module tb_param_priority_arbiter;

   logic clk;
   logic reset;
   int   checkCount;
   int   errorCount;

   param_priority_arbiter_if #(.N(4)) bus ();

   param_priority_arbiter #(
      .N        (4),
      .MAX_HOLD (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive inputs, let one rising edge happen, then settle 1 time unit past it
   task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic m);
      reset       = rst;
      bus.req     = r;
      bus.rr_mode = m;
      @(posedge clk);
      #1;
   endtask

   task automatic checkGrant(input string tag, input logic [3:0] g, input logic [1:0] id, input logic exp_pulse);
      checkOutput({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
      checkOutput({tag, ".valid"}, 32'(bus.gnt_valid), 32'(g != 4'b0000));
      checkOutput({tag, ".id"}, 32'(bus.gnt_id), 32'(id));
      checkOutput({tag, ".hexp"}, 32'(bus.hold_expired), 32'(exp_pulse));
   endtask

   initial begin
      checkCount  = 0;
      errorCount  = 0;
      reset       = 1'b1;
      bus.req     = 4'b0000;
      bus.rr_mode = 1'b0;

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'b1111, 1'b0);
         checkGrant("reset", 4'b0000, 2'd0, 1'b0);
      end

      // Fixed mode: highest wins, lock holds, same-edge handoff
      applyStimulus(1'b0, 4'b1111, 1'b0);  checkGrant("fix_all", 4'b1000, 2'd3, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b0);  checkGrant("fix_idle", 4'b0000, 2'd3, 1'b0);
      applyStimulus(1'b0, 4'b0101, 1'b0);  checkGrant("fix_0101", 4'b0100, 2'd2, 1'b0);
      applyStimulus(1'b0, 4'b1101, 1'b0);  checkGrant("fix_lock", 4'b0100, 2'd2, 1'b0);
      applyStimulus(1'b0, 4'b1001, 1'b0);  checkGrant("fix_hand", 4'b1000, 2'd3, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b0);  checkGrant("fix_rel", 4'b0000, 2'd3, 1'b0);

      // RR mode with ptr=0: order 0,1,2,3,0 with no idle gap
      applyStimulus(1'b0, 4'b1111, 1'b1);  checkGrant("rr_0", 4'b0001, 2'd0, 1'b0);
      applyStimulus(1'b0, 4'b1110, 1'b1);  checkGrant("rr_1", 4'b0010, 2'd1, 1'b0);
      applyStimulus(1'b0, 4'b1101, 1'b1);  checkGrant("rr_2", 4'b0100, 2'd2, 1'b0);
      applyStimulus(1'b0, 4'b1011, 1'b1);  checkGrant("rr_3", 4'b1000, 2'd3, 1'b0);
      applyStimulus(1'b0, 4'b0111, 1'b1);  checkGrant("rr_wrap", 4'b0001, 2'd0, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b1);  checkGrant("rr_idle", 4'b0000, 2'd0, 1'b0);

      // Requester 1 pulsing, then ptr sits at 2
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 4'b0010, 1'b1);  checkGrant("pulse_on", 4'b0010, 2'd1, 1'b0);
         applyStimulus(1'b0, 4'b0000, 1'b1);  checkGrant("pulse_off", 4'b0000, 2'd1, 1'b0);
      end
      applyStimulus(1'b0, 4'b0111, 1'b1);  checkGrant("rr_ptr2", 4'b0100, 2'd2, 1'b0);

      // Mode toggles while busy leave the owner alone; fixed mode then applies
      applyStimulus(1'b0, 4'b0111, 1'b0);  checkGrant("tog_a", 4'b0100, 2'd2, 1'b0);
      applyStimulus(1'b0, 4'b0111, 1'b1);  checkGrant("tog_b", 4'b0100, 2'd2, 1'b0);
      applyStimulus(1'b0, 4'b0011, 1'b0);  checkGrant("tog_fix", 4'b0010, 2'd1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b1);  checkGrant("tog_idle", 4'b0000, 2'd1, 1'b0);

      // Hold limit with a competitor: ptr=2 so owner 0 first
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 4'b0011, 1'b1);  checkGrant("hold_own", 4'b0001, 2'd0, 1'b0);
      end
`ifdef ARB_HOLD_LIMIT_EN
      applyStimulus(1'b0, 4'b0011, 1'b1);  checkGrant("hold_rev", 4'b0010, 2'd1, 1'b1);
      applyStimulus(1'b0, 4'b0011, 1'b1);  checkGrant("hold_after", 4'b0010, 2'd1, 1'b0);
`else
      applyStimulus(1'b0, 4'b0011, 1'b1);  checkGrant("hold_keep", 4'b0001, 2'd0, 1'b0);
      applyStimulus(1'b0, 4'b0011, 1'b1);  checkGrant("hold_keep2", 4'b0001, 2'd0, 1'b0);
`endif
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("hold_idle.valid", 32'(bus.gnt_valid), 32'd0);

      // Lone requester past the limit keeps the grant with no pulse
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 4'b0001, 1'b1);  checkGrant("solo", 4'b0001, 2'd0, 1'b0);
      end

      // Reset mid-grant clears outputs and the RR pointer
      applyStimulus(1'b1, 4'b0001, 1'b1);  checkGrant("rst_mid", 4'b0000, 2'd0, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b1);  checkGrant("rst_ptr", 4'b0001, 2'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
